pdm_mic_rx: RTL and testbench

//  Receive side of the audio path: drives the PDM microphone clock and samples the 1-bit mic stream.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/mic_clk_gen.sv | 32 +++
 rtl/pdm_mic_rx.sv | 105 ++++++++++
 tb/tb_pdm_mic_rx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the PDM capture and PWM playback paths.
// PCM sample width, full-scale limits and a saturating narrowing helper.
package audio_pkg;

    localparam int PCM_W = 16;

    localparam logic signed [PCM_W-1:0] PCM_MAX = 16'sh7FFF;
    localparam logic signed [PCM_W-1:0] PCM_MIN = 16'sh8000;

    // Narrow an 18-bit signed value to PCM width, clamping at full scale.
    function automatic logic signed [PCM_W-1:0] pcm_sat(
        input logic signed [PCM_W+1:0] v
    );
        if (v > 18'sd32767) begin
            return PCM_MAX;
        end
        if (v < -18'sd32768) begin
            return PCM_MIN;
        end
        return v[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/mic_clk_gen.sv
// Microphone clock generator: divides clk by CLK_DIV into a 50 % mic_clk
// data pin and a one-cycle strobe on the last clk of each high phase.
// Ports: clk, reset (sync, active high), en, mic_clk, strobe.
module mic_clk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mic_clk,
    output logic strobe
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div <= '0;
        end else if (div == DW'(CLK_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Gated by en so the pin parks low in the same cycle en drops.
    assign mic_clk = en && (div >= DW'(CLK_DIV / 2));
    assign strobe  = en && (div == DW'(CLK_DIV - 1));

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: synchronizes the 1-bit stream, boxcar-decimates
// DECIM bits per sample into signed PCM, delivers it over valid/ready.
// Ports: clk, reset, en, mic_data in; mic_clk, mic_lrsel, pcm, pcm_valid,
// overrun out; pcm_ready in.
module pdm_mic_rx
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int DECIM   = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mic_data,
    output logic                    mic_clk,
    output logic                    mic_lrsel,
    output logic signed [PCM_W-1:0] pcm,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int OW    = LOG2D + 1;
    localparam int XW    = PCM_W + 2;
    localparam int SH    = PCM_W - LOG2D;

    logic                    strobe;
    logic                    mic_s1;
    logic                    mic_s2;
    logic [LOG2D-1:0]        bit_cnt;
    logic [OW-1:0]           ones;
    logic [OW-1:0]           ones_tot;
    logic                    last_bit;
    logic                    complete;
    logic signed [XW-1:0]    diff;
    logic signed [XW-1:0]    scaled;
    logic signed [PCM_W-1:0] sample;

    mic_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mic_clk(mic_clk),
        .strobe (strobe)
    );

    assign mic_lrsel = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mic_s1 <= 1'b0;
            mic_s2 <= 1'b0;
        end else begin
            mic_s1 <= mic_data;
            mic_s2 <= mic_s1;
        end
    end

    // The closing bit is folded in here, so the new window starts empty.
    assign ones_tot = ones + OW'(mic_s2);
    assign last_bit = (bit_cnt == LOG2D'(DECIM - 1));
    assign complete = strobe && last_bit;

    assign diff   = $signed(XW'(ones_tot)) - $signed(XW'(DECIM / 2));
    assign scaled = diff <<< SH;
    assign sample = pcm_sat(scaled);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            ones    <= '0;
            bit_cnt <= '0;
        end else if (strobe) begin
            if (last_bit) begin
                ones    <= '0;
                bit_cnt <= '0;
            end else begin
                ones    <= ones_tot;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // A completing sample may replace a held one only when it is being
    // accepted in the same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm       <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (complete) begin
            if (pcm_valid && !pcm_ready) begin
                overrun <= 1'b1;
            end else begin
                pcm       <= sample;
                pcm_valid <= 1'b1;
            end
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed/randomized bench for pdm_mic_rx at CLK_DIV=8, DECIM=16.
// Expected PCM comes from a ones-count model of each driven window.
module tb_pdm_mic_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        mic_data = 1'b0;
    logic        mic_clk;
    logic        mic_lrsel;
    logic [15:0] pcm;
    logic        pcm_valid;
    logic        pcm_ready = 1'b1;
    logic        overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int tcnt   = 0;

    pdm_mic_rx #(
        .CLK_DIV(8),
        .DECIM  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mic_data (mic_data),
        .mic_clk  (mic_clk),
        .mic_lrsel(mic_lrsel),
        .pcm      (pcm),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] bits);
        int v;
        v = ($countones(bits) - 8) * 4096;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive nbits PDM bits, one per 8-clk mic period, aligned to en rise.
    task automatic drive(input logic [15:0] bits, input int nbits,
                         input bit rdy, input bit rdy_last,
                         input bit chk_early);
        pcm_ready = rdy;
        for (int k = 0; k < nbits; k++) begin
            mic_data = bits[k];
            for (int j = 0; j < 8; j++) begin
                if (k == nbits - 1 && j == 7) begin
                    if (chk_early) chk("early_valid", 32'(pcm_valid), 0);
                    pcm_ready = rdy_last;
                end
                @(negedge clk);
                tcnt++;
                chk("mic_clk", 32'(mic_clk), 32'((tcnt % 8) >= 4));
            end
        end
    endtask

    task automatic enable();
        en   = 1'b1;
        tcnt = 0;
    endtask

    task automatic flush();
        en        = 1'b0;
        pcm_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(pcm_valid), 0);
        chk("flush_mclk", 32'(mic_clk), 0);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] p,
                              input bit v, input bit o);
        chk({tag, "_pcm"}, 32'(pcm), 32'(p));
        chk({tag, "_valid"}, 32'(pcm_valid), 32'(v));
        chk({tag, "_ovr"}, 32'(overrun), 32'(o));
    endtask

    initial begin
        logic [15:0] a, b, r;

        repeat (3) @(negedge clk);
        chk("rst_mclk", 32'(mic_clk), 0);
        chk("rst_lrsel", 32'(mic_lrsel), 0);
        expect_out("rst", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        enable();
        drive(16'hFFFF, 16, 1, 1, 1);
        expect_out("ones1", 16'h7FFF, 1'b1, 1'b0);
        drive(16'hFFFF, 16, 1, 1, 1);
        expect_out("ones2", 16'h7FFF, 1'b1, 1'b0);
        drive(16'h0000, 16, 1, 1, 1);
        expect_out("zeros", 16'h8000, 1'b1, 1'b0);
        drive(16'hAAAA, 16, 1, 1, 1);
        expect_out("toggle", 16'h0000, 1'b1, 1'b0);
        drive(16'h0FFF, 16, 1, 1, 1);
        expect_out("twelve", 16'h4000, 1'b1, 1'b0);
        drive(16'h000F, 16, 1, 1, 1);
        expect_out("four", 16'hC000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            drive(r, 16, 1, 1, 1);
            expect_out("rand", model(r), 1'b1, 1'b0);
        end

        flush();
        enable();
        a = 16'($urandom);
        if ($countones(a) == 8) a[0] = ~a[0];
        b = ~a;
        drive(a, 16, 0, 0, 1);
        expect_out("same_a", model(a), 1'b1, 1'b0);
        drive(b, 16, 0, 1, 0);
        expect_out("same_b", model(b), 1'b1, 1'b0);

        flush();
        enable();
        drive(16'h00FF, 16, 0, 0, 1);
        expect_out("bp1", 16'h0000, 1'b1, 1'b0);
        drive(16'hFFFF, 16, 0, 0, 0);
        expect_out("bp2", 16'h0000, 1'b1, 1'b1);
        drive(16'h0000, 16, 0, 0, 0);
        expect_out("bp3", 16'h0000, 1'b1, 1'b1);
        en        = 1'b0;
        pcm_ready = 1'b1;
        @(negedge clk);
        expect_out("bp_rdy", 16'h0000, 1'b0, 1'b1);

        enable();
        drive(16'hFFFF, 9, 1, 1, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_mclk", 32'(mic_clk), 0);
        expect_out("rst2", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        tcnt  = 0;
        r = 16'($urandom);
        drive(r, 16, 1, 1, 1);
        expect_out("post_rst", model(r), 1'b1, 1'b0);

        drive(16'hFFFF, 9, 1, 1, 0);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("en_low_mclk", 32'(mic_clk), 0);
        end
        chk("en_low_valid", 32'(pcm_valid), 0);
        enable();
        drive(16'h0003, 16, 1, 1, 1);
        expect_out("reen", 16'hA000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
